// File: rtl/bitsel_share_arbiter_if.sv
// Request/response bundle for bitsel_share_arbiter: NREQ requesters in, one permuted word out.
// Handshake rule for both sides: a transfer happens on a rising CLK edge where valid and ready are both 1.
interface bitsel_share_arbiter_if #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 4,
    parameter int SELW  = 2,
    parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ*WIDTH-1:0]      req_data;
    logic [NREQ*WIDTH*SELW-1:0] req_map;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTH-1:0]           out_data;
    logic [IDW-1:0]             out_id;

    modport master (
        output req_valid, req_data, req_map, out_ready,
        input  req_ready, out_valid, out_data, out_id
    );

    modport slave (
        input  req_valid, req_data, req_map, out_ready,
        output req_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/bitsel_share_arbiter.sv
// Round-robin shared bit-select datapath with a single registered output word.
// Optional per-requester grant counters when BITSEL_SHARE_ARBITER_STATS_EN is defined.
module bitsel_share_arbiter #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 4,
    parameter int SELW  = 2,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    bitsel_share_arbiter_if.slave bus,
    output logic                  dbg_state,
    output logic [IDW-1:0]        dbg_ptr
`ifdef BITSEL_SHARE_ARBITER_STATS_EN
    ,
    input  logic                  stat_clear,
    output logic [NREQ*16-1:0]    stat_grants
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [IDW-1:0]       ptr_q;
    logic [IDW-1:0]       ptr_nxt;
    logic [NREQ-1:0]      grant;
    logic [IDW-1:0]       grant_idx;
    logic                 can_accept;
    logic                 accept;
    logic [WIDTH-1:0]     sel_data;
    logic [WIDTH*SELW-1:0] sel_map;
    logic [WIDTH-1:0]     perm_data;
    logic [WIDTH-1:0]     out_data_q;
    logic [IDW-1:0]       out_id_q;

    // RESET gates the handshake so nothing is accepted in a reset cycle.
    assign can_accept = ((state_q == EMPTY) || bus.out_ready) && !RESET;
    assign accept     = (|bus.req_valid) && can_accept;

    always_comb begin : arbiter
        int  idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int o = 0; o < NREQ; o++) begin
            idx = (int'(ptr_q) + o) % NREQ;
            if (!found && bus.req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx[IDW-1:0];
            end
        end
    end

    assign bus.req_ready = grant & {NREQ{can_accept}};

    always_comb begin
        ptr_nxt = '0;
        if (NREQ > 1) begin
            ptr_nxt = IDW'((int'(grant_idx) + 1) % NREQ);
        end
    end

    // Map entries pointing past the word fall back to bit 0.
    always_comb begin
        int src;
        sel_data  = bus.req_data[int'(grant_idx)*WIDTH +: WIDTH];
        sel_map   = bus.req_map[int'(grant_idx)*WIDTH*SELW +: WIDTH*SELW];
        perm_data = '0;
        src       = 0;
        for (int k = 0; k < WIDTH; k++) begin
            src          = int'(sel_map[k*SELW +: SELW]);
            if (src >= WIDTH) begin
                src = 0;
            end
            perm_data[k] = sel_data[src];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (bus.out_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr_q      <= '0;
            out_data_q <= '0;
            out_id_q   <= '0;
        end else if (accept) begin
            ptr_q      <= ptr_nxt;
            out_data_q <= perm_data;
            out_id_q   <= grant_idx;
        end
    end

    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;
    assign dbg_state     = state_q;
    assign dbg_ptr       = ptr_q;

`ifdef BITSEL_SHARE_ARBITER_STATS_EN
    logic [15:0] grant_cnt_q [NREQ];

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge CLK) begin
        if (RESET || stat_clear) begin
            for (int i = 0; i < NREQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (accept && grant[i] && (grant_cnt_q[i] != 16'hFFFF)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < NREQ; i++) begin
            stat_grants[i*16 +: 16] = grant_cnt_q[i];
        end
    end
`endif

endmodule

// File: doc/bitsel_share_arbiter.md
Name: bitsel_share_arbiter

Overview:
- Shares one registered bit-select (array-select) datapath between NREQ requesters.
- Each requester presents a WIDTH-bit data word and a per-bit select map. The block arbitrates round-robin, applies the granted requester's map, and returns the permuted word tagged with the requester ID.
- Sits between bit-select clients and the downstream consumer of permuted words.

Parameters:
- NREQ, 2, number of requesters (2..8).
- WIDTH, 4, data word width in bits.
- SELW, 2, bits per select-map entry; must satisfy 2^SELW >= WIDTH.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_data  input  NREQ*WIDTH  requester i uses bits [i*WIDTH +: WIDTH].
- req_map  input  NREQ*WIDTH*SELW  requester i uses bits [i*WIDTH*SELW +: WIDTH*SELW]. Entry k, at bits [k*SELW +: SELW], is the source bit index for output bit k.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accept.
- out_data  output  WIDTH  permuted word.
- out_id  output  clog2(NREQ) (min 1)  index of the requester that produced out_data.

Behaviour:
- Reset is synchronous, active-high, on CLK.
  - Reset values: out_valid=0, out_data=0, out_id=0, req_ready=0, round-robin pointer=0, state=EMPTY.
  - Reset mid-operation discards any held output word; no handshake completes in a cycle where RESET=1.
- State machine has two states: EMPTY and FULL (output register holds a word).
  - can_accept = (state==EMPTY) | out_ready.
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY when out_ready=1 and there is no accept.
  - FULL -> FULL when out_ready=0, or on simultaneous drain+accept (no bubble; back-to-back throughput is 1 word/cycle).
- Arbitration is combinational and round-robin.
  - Search order starts at the pointer and wraps modulo NREQ. The first i with req_valid[i]=1 is granted.
  - req_ready[i] = can_accept & grant[i].
  - Accept = any req_valid & can_accept.
  - On accept, the pointer becomes (granted+1) mod NREQ. Without an accept, the pointer holds.
  - Requester 0 has highest priority after reset.
- Datapath latency is 1 cycle from the accept edge to out_valid.
  - On accept: out_data[k] <= req_data[g][ req_map[g][k] ] for every k; out_id <= g.
  - Map entries >= WIDTH select bit 0.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_id hold and req_ready is all-zero.
- Requester-side rules:
  - A requester may drop req_valid before being accepted; nothing is captured.
  - req_data and req_map are sampled only in the accept cycle.
- Boundary cases:
  - NREQ=1: the pointer is constant 0.
  - All req_valid low: no state change apart from the drain.

Optional Feature:
- Macro: BITSEL_SHARE_ARBITER_STATS_EN.
- When defined, the block adds output stat_grants (NREQ*16 bits): per-requester 16-bit grant counters.
  - A counter increments on each accept for its requester and saturates at 0xFFFF.
  - Counters clear on RESET.
  - Also adds input stat_clear (1 bit); stat_clear=1 zeroes all counters synchronously and takes priority over an increment in the same cycle.
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Map evaluation: RESET 2 cycles; req_valid=01, req_data[0]=4'b0101, req_map[0]=8'h90 (out3=I2, out2=I1, out1=I0, out0=I0), out_ready=1 -> req_ready=01 same cycle; next cycle out_valid=1, out_data=4'b1011, out_id=0.
- Round-robin: req_valid=11 held, out_ready=1, both maps 8'hE4 (identity), data0=4'h3, data1=4'hC -> outputs alternate id 0,1,0,1 with data 3,C,3,C, one per cycle, no bubbles.
- Backpressure: FULL with out_ready=0 for 3 cycles while req_valid=11 -> req_ready=00, out_data/out_id unchanged. Raise out_ready -> the next word appears the following cycle, and the grant goes to the requester after the last granted.
- Reset mid-operation: FULL with out_ready=0; assert RESET 1 cycle -> out_valid=0, out_data=0, pointer=0. Then with req_valid=11, requester 0 is granted first.
- Stats (with BITSEL_SHARE_ARBITER_STATS_EN): 5 accepts of req 1 and 3 of req 0 -> stat_grants = {16'd5,16'd3}. Pulse stat_clear alongside an accept -> all counters read 0 next cycle.
